// File: rtl/rf_hazard_pkg.sv
// rtl/rf_hazard_pkg.sv - shared opcodes, instruction classes and tracking entry type for the RF hazard unit
package rf_hazard_pkg;

    // Register fields in the 8-bit instruction word are two bits wide
    localparam int REG_W = 2;
    localparam logic [REG_W-1:0] K1_REG = 2'd1;

    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_STOP  = 4'b0001;
    localparam logic [3:0] OP_STORE = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0100;
    localparam logic [3:0] OP_BZ    = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_NAND  = 4'b1000;
    localparam logic [3:0] OP_BNZ   = 4'b1001;
    localparam logic [3:0] OP_NOP   = 4'b1010;
    localparam logic [3:0] OP_BPZ   = 4'b1101;
    localparam logic [2:0] OP_SHIFT_LO = 3'b011;
    localparam logic [2:0] OP_ORI_LO   = 3'b111;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_SHIFT,
        CLS_ORI,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_NOP,
        CLS_STOP
    } instr_cls_t;

    // One in-flight destination slot: stage k of the tracking pipeline
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
        logic             is_load;
    } trk_entry_t;

endpackage

// File: rtl/rf_instr_decode.sv
// rtl/rf_instr_decode.sv - combinational decode of the RF-stage instruction into operand/write info
module rf_instr_decode
    import rf_hazard_pkg::*;
(
    input  logic [7:0]       rf_instr,
    output instr_cls_t       cls,
    output logic             rd_r1,
    output logic             rd_r2,
    output logic [REG_W-1:0] src1,
    output logic [REG_W-1:0] src2,
    output logic [REG_W-1:0] dest,
    output logic             writes,
    output logic             is_load,
    output logic             sets_flags
);

    logic [3:0] op;
    assign op = rf_instr[3:0];

    // Classify the opcode; unlisted encodings behave as NOP
    always_comb begin
        cls = CLS_NOP;
        if (op == OP_ADD || op == OP_SUB || op == OP_NAND) begin
            cls = CLS_ALU;
        end else if (op[2:0] == OP_SHIFT_LO) begin
            cls = CLS_SHIFT;
        end else if (op[2:0] == OP_ORI_LO) begin
            cls = CLS_ORI;
        end else if (op == OP_LOAD) begin
            cls = CLS_LOAD;
        end else if (op == OP_STORE) begin
            cls = CLS_STORE;
        end else if (op == OP_BPZ || op == OP_BZ || op == OP_BNZ) begin
            cls = CLS_BRANCH;
        end else if (op == OP_STOP) begin
            cls = CLS_STOP;
        end
    end

    // Operand usage and destination derived from the class; ORI implicitly uses k1
    always_comb begin
        rd_r1      = (cls == CLS_ALU) || (cls == CLS_SHIFT) || (cls == CLS_ORI) || (cls == CLS_STORE);
        rd_r2      = (cls == CLS_ALU) || (cls == CLS_LOAD) || (cls == CLS_STORE);
        writes     = (cls == CLS_ALU) || (cls == CLS_SHIFT) || (cls == CLS_ORI) || (cls == CLS_LOAD);
        is_load    = (cls == CLS_LOAD);
        sets_flags = (cls == CLS_ALU) || (cls == CLS_SHIFT) || (cls == CLS_ORI);
        src1       = (cls == CLS_ORI) ? K1_REG : rf_instr[7:6];
        src2       = rf_instr[5:4];
        dest       = (cls == CLS_ORI) ? K1_REG : rf_instr[7:6];
    end

endmodule

// File: rtl/rf_hazard_unit.sv
// rtl/rf_hazard_unit.sv - RF-stage forwarding select and stall control over a tracked destination pipeline
module rf_hazard_unit
    import rf_hazard_pkg::*;
#(
    parameter  int REG_AW     = 2,
    parameter  int DEPTH      = 3,
    parameter  int ALU_AVAIL  = 2,
    parameter  int LOAD_AVAIL = 3,
    localparam int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       rf_instr,
    input  logic             rf_valid,
    input  logic             flush,
    output logic             issue,
    output logic             ir_load,
    output logic             stall,
    output logic [SEL_W-1:0] r1_fwd_sel,
    output logic [SEL_W-1:0] r2_fwd_sel,
    output logic             r1_sel,
    output logic             flag_write,
    output logic             halted
);

    instr_cls_t        cls;
    logic              rd_r1, rd_r2, writes, is_load, sets_flags;
    logic [REG_W-1:0]  dec_src1, dec_src2, dec_dest;
    logic [REG_AW-1:0] src1, src2;

    trk_entry_t trk_q [1:DEPTH];
    trk_entry_t trk_d [1:DEPTH];
    logic       halted_q, halted_d;

    logic hit1, hit2, ld1, ld2, haz1, haz2, active;
    int   k1, k2;

    rf_instr_decode u_decode (
        .rf_instr   (rf_instr),
        .cls        (cls),
        .rd_r1      (rd_r1),
        .rd_r2      (rd_r2),
        .src1       (dec_src1),
        .src2       (dec_src2),
        .dest       (dec_dest),
        .writes     (writes),
        .is_load    (is_load),
        .sets_flags (sets_flags)
    );

    assign src1 = dec_src1;
    assign src2 = dec_src2;

    // Youngest matching producer per operand: scan oldest to youngest so the smallest stage wins
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        ld1  = 1'b0;
        ld2  = 1'b0;
        k1   = 0;
        k2   = 0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (trk_q[k].valid && trk_q[k].dest == src1) begin
                hit1 = 1'b1;
                ld1  = trk_q[k].is_load;
                k1   = k;
            end
            if (trk_q[k].valid && trk_q[k].dest == src2) begin
                hit2 = 1'b1;
                ld2  = trk_q[k].is_load;
                k2   = k;
            end
        end
    end

    // Hazard, stall/issue and forward selects; reset forces every output to its idle value
    always_comb begin
        haz1       = rd_r1 && hit1 && (k1 < (ld1 ? LOAD_AVAIL : ALU_AVAIL));
        haz2       = rd_r2 && hit2 && (k2 < (ld2 ? LOAD_AVAIL : ALU_AVAIL));
        active     = rf_valid && !flush && !halted_q && !reset;
        stall      = active && (haz1 || haz2);
        issue      = active && !stall;
        ir_load    = !stall;
        r1_fwd_sel = (!reset && rd_r1 && hit1 && !haz1) ? SEL_W'(k1) : '0;
        r2_fwd_sel = (!reset && rd_r2 && hit2 && !haz2) ? SEL_W'(k2) : '0;
        r1_sel     = !reset && (cls == CLS_ORI);
        flag_write = issue && sets_flags;
        halted     = halted_q;
    end

    // Next tracking state: shift every cycle, stage 1 takes the issuing writer or a bubble
    always_comb begin
        trk_d[1] = '0;
        if (issue && writes) begin
            trk_d[1].valid   = 1'b1;
            trk_d[1].dest    = dec_dest;
            trk_d[1].is_load = is_load;
        end
        for (int k = 2; k <= DEPTH; k++) begin
            trk_d[k] = trk_q[k-1];
        end
        halted_d = halted_q || (issue && (cls == CLS_STOP));
    end

    // Tracking pipeline and sticky halt register
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 1; k <= DEPTH; k++) begin
                trk_q[k] <= '0;
            end
            halted_q <= 1'b0;
        end else begin
            for (int k = 1; k <= DEPTH; k++) begin
                trk_q[k] <= trk_d[k];
            end
            halted_q <= halted_d;
        end
    end

endmodule

// File: tb/tb_rf_hazard_unit.sv
// tb/tb_rf_hazard_unit.sv - scoreboard bench for rf_hazard_unit with a history-based reference model
module tb_rf_hazard_unit;

    localparam int DEPTH      = 3;
    localparam int ALU_AVAIL  = 2;
    localparam int LOAD_AVAIL = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rf_instr = 8'h0A;
    logic       rf_valid = 1'b0;
    logic       flush = 1'b0;
    logic       issue, ir_load, stall, r1_sel, flag_write, halted;
    logic [1:0] r1_fwd_sel, r2_fwd_sel;

    rf_hazard_unit dut (
        .clock      (clock),
        .reset      (reset),
        .rf_instr   (rf_instr),
        .rf_valid   (rf_valid),
        .flush      (flush),
        .issue      (issue),
        .ir_load    (ir_load),
        .stall      (stall),
        .r1_fwd_sel (r1_fwd_sel),
        .r2_fwd_sel (r2_fwd_sel),
        .r1_sel     (r1_sel),
        .flag_write (flag_write),
        .halted     (halted)
    );

    always #5 clock = ~clock;

    typedef struct {
        int step;
        bit issue, stall, ir_load, r1s, fw, hl;
        int s1, s2;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   n_step = 0;

    // Reference model: what was issued 1..DEPTH cycles ago (age == pipeline stage)
    bit   h_v [1:DEPTH];
    int   h_d [1:DEPTH];
    bit   h_l [1:DEPTH];
    bit   m_halted   = 1'b0;
    bit   last_stall = 1'b0;

    task automatic chk(input string nm, input int st, input int act, input int ex);
        n_cmp++;
        if (act != ex) begin
            n_bad++;
            $display("FAIL %s step=%0d got=%0d expected=%0d", nm, st, act, ex);
        end
    endtask

    function automatic void find(input int src, input bit used, output bit haz, output int sel);
        haz = 1'b0;
        sel = 0;
        if (!used) return;
        for (int age = 1; age <= DEPTH; age++) begin
            if (h_v[age] && h_d[age] == src) begin
                if (age >= (h_l[age] ? LOAD_AVAIL : ALU_AVAIL)) sel = age;
                else haz = 1'b1;
                return;
            end
        end
    endfunction

    task automatic step(input logic [7:0] ins, input bit v, input bit fl, input bit rs);
        exp_t e;
        int op, s1, s2, dst, sel1, sel2;
        bit rd1, rd2, wr, ld, fset, is_stop, is_ori, hz1, hz2, act;
        @(posedge clock);
        #1;
        rf_instr = ins;
        rf_valid = v;
        flush    = fl;
        reset    = rs;
        n_step++;
        op  = int'(ins[3:0]);
        s1  = int'(ins[7:6]);
        s2  = int'(ins[5:4]);
        dst = s1;
        {rd1, rd2, wr, ld, fset, is_stop, is_ori} = '0;
        case (op)
            4, 6, 8:   begin rd1 = 1; rd2 = 1; wr = 1; fset = 1; end
            3, 11:     begin rd1 = 1; wr = 1; fset = 1; end
            7, 15:     begin rd1 = 1; wr = 1; fset = 1; is_ori = 1; s1 = 1; dst = 1; end
            0:         begin rd2 = 1; wr = 1; ld = 1; end
            2:         begin rd1 = 1; rd2 = 1; end
            1:         is_stop = 1;
            default:   ;
        endcase
        find(s1, rd1, hz1, sel1);
        find(s2, rd2, hz2, sel2);
        act       = v && !fl && !m_halted && !rs;
        e.step    = n_step;
        e.stall   = act && (hz1 || hz2);
        e.issue   = act && !e.stall;
        e.ir_load = !e.stall;
        e.s1      = rs ? 0 : sel1;
        e.s2      = rs ? 0 : sel2;
        e.r1s     = !rs && is_ori;
        e.fw      = e.issue && fset;
        e.hl      = m_halted;
        exp_q.push_back(e);
        last_stall = e.stall;
        if (rs) begin
            for (int a = 1; a <= DEPTH; a++) h_v[a] = 1'b0;
            m_halted = 1'b0;
        end else begin
            for (int a = DEPTH; a >= 2; a--) begin
                h_v[a] = h_v[a-1];
                h_d[a] = h_d[a-1];
                h_l[a] = h_l[a-1];
            end
            h_v[1] = e.issue && wr;
            h_d[1] = dst;
            h_l[1] = ld;
            if (e.issue && is_stop) m_halted = 1'b1;
        end
    endtask

    // Keep presenting an instruction until it leaves the RF stage (bounded)
    task automatic present(input logic [7:0] ins);
        step(ins, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8 && last_stall; i++) step(ins, 1'b1, 1'b0, 1'b0);
    endtask

    // Monitor: compare every presented output cycle against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("issue",      e.step, int'(issue),      int'(e.issue));
                chk("stall",      e.step, int'(stall),      int'(e.stall));
                chk("ir_load",    e.step, int'(ir_load),    int'(e.ir_load));
                chk("r1_fwd_sel", e.step, int'(r1_fwd_sel), e.s1);
                chk("r2_fwd_sel", e.step, int'(r2_fwd_sel), e.s2);
                chk("r1_sel",     e.step, int'(r1_sel),     int'(e.r1s));
                chk("flag_write", e.step, int'(flag_write), int'(e.fw));
                chk("halted",     e.step, int'(halted),     int'(e.hl));
            end
        end
    end

    initial begin
        logic [7:0] ins;
        bit rs, fl, v;
        int op;
        for (int a = 1; a <= DEPTH; a++) begin
            h_v[a] = 1'b0;
            h_d[a] = 0;
            h_l[a] = 1'b0;
        end
        step(8'h0A, 1'b0, 1'b0, 1'b1);
        step(8'h0A, 1'b0, 1'b0, 1'b1);
        // ALU back-to-back dependency
        present(8'hB4);
        present(8'h24);
        // load-use
        present(8'h40);
        present(8'h54);
        // writer, NOP, reader; then consecutive r2 writers
        present(8'hA4);
        present(8'h0A);
        present(8'h24);
        present(8'h84);
        present(8'h84);
        present(8'h24);
        // ORI after ADD r1
        present(8'h74);
        present(8'h0F);
        // hazard and flush together
        present(8'hB4);
        step(8'h24, 1'b1, 1'b1, 1'b0);
        step(8'h0A, 1'b1, 1'b0, 1'b0);
        // STOP then attempted issue
        present(8'h01);
        present(8'hB4);
        step(8'h24, 1'b1, 1'b0, 1'b0);
        // reset during a load-use stall
        step(8'h0A, 1'b0, 1'b0, 1'b1);
        present(8'h40);
        step(8'h54, 1'b1, 1'b0, 1'b0);
        step(8'h54, 1'b1, 1'b0, 1'b1);
        step(8'h54, 1'b1, 1'b0, 1'b0);
        // randomized traffic; held while stalled like a real IR
        ins = 8'h0A;
        for (int i = 0; i < 3000; i++) begin
            if (!last_stall) begin
                op = $urandom_range(0, 15);
                if (op == 1 && $urandom_range(0, 9) != 0) op = 4;
                ins = {$urandom_range(0, 15) > 7 ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)),
                       2'($urandom_range(0, 3)), 4'(op)};
            end
            rs = ($urandom_range(0, 59) == 0);
            fl = ($urandom_range(0, 7) == 0);
            v  = ($urandom_range(0, 7) != 0);
            step(ins, v, fl, rs);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        chk("scoreboard_drain", n_step, exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rf_hazard_unit.md
# rf_hazard_unit

Parametrised register-fetch (RF) stage hazard controller for the pipelined 8-bit core. It replaces the fixed writeback-only forwarding with a tracked in-flight destination pipeline of configurable depth. It chooses, per source operand, the youngest in-flight producer whose result is available, and it stalls the RF stage when that producer's result is not yet available. It sits beside the RF stage and drives the IR load enable, the R1/R2 operand muxes, R1Sel and FlagWrite.

## Interface
- `REG_AW`, 2: register address width; `NUM_REGS = 2**REG_AW`.
- `DEPTH`, 3: tracked stages after RF (stage 1 = EX, stage `DEPTH` = WB); range 2..7.
- `ALU_AVAIL`, 2: first stage index holding ALU/shift/ORI results; range 1..`DEPTH`.
- `LOAD_AVAIL`, 3: first stage index holding load data; range `ALU_AVAIL`..`DEPTH`.
- `SEL_W`, `$clog2(DEPTH+1)`: forward-select width (derived, do not override).

Ports:
- `clock` in 1: single clock.
- `reset` in 1: reset is synchronous and active-high.
- `rf_instr` in 8: instruction in RF stage. Fields: `[7:6]` R1, `[5:4]` R2, `[3:0]` opcode.
- `rf_valid` in 1: `rf_instr` is a real instruction.
- `flush` in 1: taken branch; the RF-stage instruction is killed this cycle.
- `issue` out 1: RF instruction advances into stage 1 at this edge.
- `ir_load` out 1: IR load enable; equals `~stall`.
- `stall` out 1: hold IR and PC.
- `r1_fwd_sel`, `r2_fwd_sel` out `SEL_W`: 0 = register file, k = result from stage k.
- `r1_sel` out 1: R1 read address forced to k1 (ORI).
- `flag_write` out 1: flag update for the issuing instruction.
- `halted` out 1: sticky after STOP issues.

## Operation
- Decode (opcode): ADD 0100, SUB 0110, NAND 1000 read R1,R2 and write R1. SHIFT `[2:0]=011` reads/writes R1. ORI `[2:0]=111` reads/writes k1 (register 1). LOAD 0000 reads R2 and writes R1. STORE 0010 reads R1,R2. BPZ 1101, BZ 0101, BNZ 1001 read only flags. NOP 1010. STOP 0001. Any other opcode is treated as NOP.
- Tracking pipeline: entries 1..`DEPTH`, each `{valid, dest[REG_AW-1:0], is_load}`.
  - Every clock, entry k+1 <= entry k. Entry `DEPTH` is discarded.
  - Entry 1 <= the issued instruction's write info, or a bubble (valid=0) when not issuing or when the instruction does not write.
- Per source operand that is read:
  - Find the smallest k with entry k valid and dest matching the source.
  - If no match: sel=0.
  - Available when k ≥ (`is_load` ? `LOAD_AVAIL` : `ALU_AVAIL`): sel=k.
  - Otherwise: raise `stall`, sel=0.
- Unused sources: sel=0, no stall contribution.
- `stall` = `rf_valid & ~flush & ~halted & (hazard on R1 | hazard on R2)`.
- `issue` = `rf_valid & ~flush & ~halted & ~stall`.
- `r1_sel` = 1 for ORI, else 0.
- `flag_write` = `issue` & (ADD|SUB|NAND|SHIFT|ORI).
- STOP: `halted` is set at the edge where STOP issues. While `halted`, `issue`=0, `stall`=0, `ir_load`=1 and bubbles drain the pipeline. Only `reset` clears `halted`.
- `flush` and hazard in the same cycle: flush wins. `stall`=0, `issue`=0, a bubble enters stage 1. Tracked entries are older than the branch and are never killed.
- Decided dependency penalties with defaults: back-to-back ALU dependency stalls 1 cycle; load-use stalls 2 cycles.

## Timing
- Decode, match, `stall`, sel, `issue`, `r1_sel` and `flag_write` are combinational from `rf_instr` and the tracking state, valid in the same cycle.
- Tracking and `halted` update on the `clock` rising edge.
- Reset, synchronous: all entries valid=0, `halted`=0.
- While `reset` is high: `issue`=0, `stall`=0, `ir_load`=1, both sels=0, `r1_sel`=0, `flag_write`=0.
- Reset asserted mid-stall: the stall ends in the same cycle and no partial entry survives.
- Stall length for a producer at stage k needing availability stage A is `A-k` cycles. The sel then equals A on the issuing cycle.

## Structure
- Package `rf_hazard_pkg`:
  - opcode constants;
  - instruction class enum (ALU, SHIFT, ORI, LOAD, STORE, BRANCH, NOP, STOP);
  - tracking-entry struct typedef;
  - constant `K1_REG = 1`.
- Sub-module `rf_instr_decode` (combinational): `rf_instr` → class, read-R1/read-R2 flags, dest, writes, is_load. Instantiated once.

## Test plan
- Default parameters. Issue `8'hB4` (ADD r2,r3), then `8'h24` (ADD r0,r2) → one cycle with `stall`=1 and `ir_load`=0; next cycle `issue`=1, `r2_fwd_sel`=2, `r1_fwd_sel`=0.
- `8'h40` (LOAD r1←[r0]), then `8'h54` (ADD r1,r1) → 2 stall cycles; then `r1_fwd_sel`=`r2_fwd_sel`=3, `flag_write`=1.
- ADD r2 then NOP then an instruction reading r2 → no stall, sel=2. With two in-flight writers to r2 at stages 2 and 3 → sel=2 (youngest wins).
- ORI (`8'h0F`) after ADD r1 (`8'h74`) → `r1_sel`=1, one stall cycle, then `r1_fwd_sel`=2.
- Hazard with `flush`=1 in the same cycle → `stall`=0, `issue`=0. Stage 1 holds a bubble next cycle.
- STOP (`8'h01`) → `halted`=1 after the edge and `issue` stays 0. Asserting `reset` during a load-use stall → all outputs return to reset values the next cycle, and `halted`=0.
